// File: rtl/bf_pkg.sv
// Shared encodings for the BF host responder: ASIC op codes, FSM states and
// bit positions inside the ASIC-facing status bytes.
package bf_pkg;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_IN    = 2'b01,
        OP_OUT   = 2'b10,
        OP_HALT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOOKUP = 2'b01,
        ACK    = 2'b10,
        DROP   = 2'b11
    } state_e;

    localparam int REQ_BIT = 7;
    localparam int ACK_BIT = 7;
    localparam int EOF_BIT = 6;

endpackage

// File: rtl/bf_byte_fifo.sv
// Show-ahead byte FIFO; rdata reads 0x00 whenever the FIFO is empty.
module bf_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bf_host_responder.sv
// Host-side responder for a BF ASIC: serves FETCH/IN/OUT/HALT requests over a
// four-phase req/ack handshake, backed by program memory and two byte FIFOs.
//
// state  | meaning
// IDLE   | waiting for req; latches op, address and data byte
// LOOKUP | serving the request; may stall on empty input / full output
// ACK    | ack held high until req drops
// DROP   | one-cycle gap so a new req is never taken as ack falls
module bf_host_responder
    import bf_pkg::*;
#(
    parameter int PROG_DEPTH = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  asic_uo,
    input  logic [7:0]  asic_uio,
    output logic [7:0]  asic_ui,
    output logic [7:0]  asic_uio_in,
    input  logic        prog_we,
    input  logic [12:0] prog_addr,
    input  logic [7:0]  prog_wdata,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        in_eof,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halted,
    output logic        busy
);
    localparam int         AW         = $clog2(PROG_DEPTH);
    localparam logic [13:0] PROG_LIMIT = 14'(PROG_DEPTH);

    state_e      state_q, state_d;
    op_e         op_q;
    logic [12:0] addr_q;
    logic [7:0]  byte_q;
    logic        fetch_wait_q;
    logic        ack_q, eof_q, halted_q;
    logic [7:0]  data_q;

    logic [7:0]  prog_mem [PROG_DEPTH];
    logic [7:0]  rd_q;
    logic        fetch_ok;

    logic        take_req, in_pop, out_push, ack_set, ack_clr, eof_d, halt_set;
    logic [7:0]  data_d;
    logic [7:0]  in_head;
    logic        in_full, in_empty, out_full, out_empty;

    bf_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk(clk), .rst(rst), .push(in_valid), .wdata(in_data), .pop(in_pop),
        .rdata(in_head), .full(in_full), .empty(in_empty)
    );

    bf_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk(clk), .rst(rst), .push(out_push), .wdata(byte_q), .pop(out_ready),
        .rdata(out_data), .full(out_full), .empty(out_empty)
    );

    // Read port is free-running on the latched address, so a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (prog_we && ({1'b0, prog_addr} < PROG_LIMIT))
            prog_mem[prog_addr[AW-1:0]] <= prog_wdata;
        rd_q <= prog_mem[addr_q[AW-1:0]];
    end

    assign fetch_ok = ({1'b0, addr_q} < PROG_LIMIT);

    always_comb begin
        state_d  = state_q;
        take_req = 1'b0;
        in_pop   = 1'b0;
        out_push = 1'b0;
        ack_set  = 1'b0;
        ack_clr  = 1'b0;
        eof_d    = 1'b0;
        halt_set = 1'b0;
        data_d   = 8'h00;
        case (state_q)
            IDLE: begin
                if (asic_uo[REQ_BIT]) begin
                    take_req = 1'b1;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                unique case (op_q)
                    OP_FETCH: begin
                        if (fetch_wait_q) begin
                            ack_set = 1'b1;
                            data_d  = fetch_ok ? rd_q : 8'h00;
                            state_d = ACK;
                        end
                    end
                    OP_IN: begin
                        if (!in_empty) begin
                            in_pop  = 1'b1;
                            ack_set = 1'b1;
                            data_d  = in_head;
                            state_d = ACK;
                        end else if (in_eof) begin
                            ack_set = 1'b1;
                            eof_d   = 1'b1;
                            state_d = ACK;
                        end
                    end
                    OP_OUT: begin
                        if (!out_full) begin
                            out_push = 1'b1;
                            ack_set  = 1'b1;
                            state_d  = ACK;
                        end
                    end
                    OP_HALT: begin
                        halt_set = 1'b1;
                        ack_set  = 1'b1;
                        state_d  = ACK;
                    end
                endcase
            end
            ACK: begin
                if (!asic_uo[REQ_BIT]) begin
                    ack_clr = 1'b1;
                    state_d = DROP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_FETCH;
            addr_q       <= '0;
            byte_q       <= '0;
            fetch_wait_q <= 1'b0;
            ack_q        <= 1'b0;
            eof_q        <= 1'b0;
            data_q       <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_wait_q <= (state_q == LOOKUP) && (op_q == OP_FETCH) && !fetch_wait_q;
            if (take_req) begin
                op_q   <= op_e'(asic_uo[6:5]);
                addr_q <= {asic_uo[4:0], asic_uio};
                byte_q <= asic_uio;
            end
            if (ack_set) begin
                ack_q  <= 1'b1;
                eof_q  <= eof_d;
                data_q <= data_d;
            end
            if (ack_clr)  ack_q    <= 1'b0;
            if (halt_set) halted_q <= 1'b1;
        end
    end

    always_comb begin
        asic_ui          = 8'h00;
        asic_ui[ACK_BIT] = ack_q;
        asic_ui[EOF_BIT] = eof_q;
    end

    assign asic_uio_in = data_q;
    assign in_ready    = ~in_full;
    assign out_valid   = ~out_empty;
    assign halted      = halted_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_bf_host_responder.sv
// Directed bench for bf_host_responder: handshake latency, FIFO stalls,
// program-memory bounds, HALT and mid-handshake reset.
module tb_bf_host_responder;
    import bf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  asic_uo = '0;
    logic [7:0]  asic_uio = '0;
    logic [7:0]  asic_ui;
    logic [7:0]  asic_uio_in;
    logic        prog_we = 1'b0;
    logic [12:0] prog_addr = '0;
    logic [7:0]  prog_wdata = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        in_eof = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        halted;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    bf_host_responder #(.PROG_DEPTH(256), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .asic_uo(asic_uo), .asic_uio(asic_uio),
        .asic_ui(asic_ui), .asic_uio_in(asic_uio_in),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .in_eof(in_eof),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_start(input logic [1:0] op, input logic [12:0] addr, input logic [7:0] data);
        asic_uo  = {1'b1, op, addr[12:8]};
        asic_uio = (op == OP_FETCH) ? addr[7:0] : data;
    endtask

    task automatic end_hs();
        asic_uo = 8'h00;
        tick();
        check("ack_fall", {31'd0, asic_ui[7]}, 32'd0);
        tick();
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_ack(input string tag, input int max_cyc);
        int k = 0;
        while (!asic_ui[7] && k < max_cyc) begin
            tick();
            k++;
        end
        check(tag, {31'd0, asic_ui[7]}, 32'd1);
    endtask

    task automatic prog_write(input logic [12:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic push_in(input logic [7:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic fetch_check(input logic [12:0] a, input logic [7:0] exp);
        req_start(OP_FETCH, a, 8'h00);
        tick();
        tick();
        check("fetch_ack_n1", {31'd0, asic_ui[7]}, 32'd0);
        tick();
        check("fetch_ack_n2", {31'd0, asic_ui[7]}, 32'd1);
        check("fetch_data", {24'd0, asic_uio_in}, {24'd0, exp});
        end_hs();
    endtask

    task automatic in_check(input logic [7:0] exp_data, input logic exp_eof);
        req_start(OP_IN, 13'd0, 8'h00);
        tick();
        check("in_ack_n", {31'd0, asic_ui[7]}, 32'd0);
        tick();
        check("in_ack_n1", {31'd0, asic_ui[7]}, 32'd1);
        check("in_data", {24'd0, asic_uio_in}, {24'd0, exp_data});
        check("in_eof", {31'd0, asic_ui[6]}, {31'd0, exp_eof});
        end_hs();
    endtask

    initial begin
        tick();
        tick();
        check("rst_ui", {24'd0, asic_ui}, 32'h00);
        check("rst_uio_in", {24'd0, asic_uio_in}, 32'h00);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        prog_write(13'd5, 8'h2B);
        prog_write(13'd44, 8'h11);
        prog_write(13'd300, 8'h55);

        // FETCH addr 5 with explicit edge-by-edge latency
        req_start(OP_FETCH, 13'd5, 8'h00);
        tick();
        check("fetch_busy", {31'd0, busy}, 32'd1);
        check("fetch_ack_n", {31'd0, asic_ui[7]}, 32'd0);
        tick();
        check("fetch_ack_n1", {31'd0, asic_ui[7]}, 32'd0);
        tick();
        check("fetch_ack_n2", {31'd0, asic_ui[7]}, 32'd1);
        check("fetch_data", {24'd0, asic_uio_in}, 32'h2B);
        end_hs();

        // write lands on the same edge as the read: old data returned
        req_start(OP_FETCH, 13'd5, 8'h00);
        tick();
        prog_we = 1'b1; prog_addr = 13'd5; prog_wdata = 8'h77;
        tick();
        prog_we = 1'b0;
        tick();
        check("rw_collide_ack", {31'd0, asic_ui[7]}, 32'd1);
        check("rw_collide_old", {24'd0, asic_uio_in}, 32'h2B);
        end_hs();
        fetch_check(13'd5, 8'h77);
        fetch_check(13'd44, 8'h11);
        fetch_check(13'd300, 8'h00);

        // IN stalls on empty FIFO without eof
        req_start(OP_IN, 13'd0, 8'h00);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("in_stall", {31'd0, asic_ui[7]}, 32'd0);
        end
        push_in(8'h41);
        check("in_push_edge", {31'd0, asic_ui[7]}, 32'd0);
        tick();
        check("in_late_ack", {31'd0, asic_ui[7]}, 32'd1);
        check("in_late_data", {24'd0, asic_uio_in}, 32'h41);
        check("in_late_eof", {31'd0, asic_ui[6]}, 32'd0);
        end_hs();

        push_in(8'h10);
        push_in(8'h20);
        in_check(8'h10, 1'b0);
        in_check(8'h20, 1'b0);
        in_eof = 1'b1;
        in_check(8'h00, 1'b1);
        in_eof = 1'b0;

        // OUT: fill the output FIFO, ninth request stalls
        for (int i = 0; i < 8; i++) begin
            req_start(OP_OUT, 13'd0, 8'(i));
            tick();
            tick();
            check("out_ack", {31'd0, asic_ui[7]}, 32'd1);
            end_hs();
        end
        req_start(OP_OUT, 13'd0, 8'h08);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("out_stall", {31'd0, asic_ui[7]}, 32'd0);
        end
        check("out_head0", {24'd0, out_data}, 32'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_ack("out_9th_ack", 4);
        end_hs();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("out_data", {24'd0, out_data}, k);
            tick();
        end
        out_ready = 1'b0;
        check("out_drained", {31'd0, out_valid}, 32'd0);

        // HALT
        req_start(OP_HALT, 13'd0, 8'h00);
        tick();
        check("halt_n", {31'd0, halted}, 32'd0);
        tick();
        check("halt_n1", {31'd0, halted}, 32'd1);
        check("halt_ack", {31'd0, asic_ui[7]}, 32'd1);
        check("halt_data", {24'd0, asic_uio_in}, 32'h00);
        end_hs();
        fetch_check(13'd5, 8'h77);
        check("halt_sticky", {31'd0, halted}, 32'd1);

        // reset during ACK of an IN
        for (int i = 0; i < 8; i++) push_in(8'hA0 + 8'(i));
        check("in_full", {31'd0, in_ready}, 32'd0);
        req_start(OP_IN, 13'd0, 8'h00);
        tick();
        tick();
        check("pre_rst_ack", {31'd0, asic_ui[7]}, 32'd1);
        check("pre_rst_data", {24'd0, asic_uio_in}, 32'hA0);
        rst = 1'b1;
        asic_uo = 8'h00;
        tick();
        check("mid_rst_ui", {24'd0, asic_ui}, 32'h00);
        check("mid_rst_uio_in", {24'd0, asic_uio_in}, 32'h00);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_halted", {31'd0, halted}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        in_eof = 1'b1;
        in_check(8'h00, 1'b1);
        in_eof = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bf_host_responder.md
BF_HOST_RESPONDER -- requirements
Module: bf_host_responder

Interface
REQ-001 Parameter PROG_DEPTH, default 256, program memory depth in bytes, power of two, at most 8192.
REQ-002 Parameter FIFO_DEPTH, default 8, depth of each of the input and output byte FIFOs, power of two.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 asic_uo  in  8  ASIC uo_out: [7] req, [6:5] op (00 FETCH, 01 IN, 10 OUT, 11 HALT), [4:0] fetch address bits [12:8].
REQ-006 asic_uio  in  8  ASIC uio_out: fetch address bits [7:0] for FETCH, data byte for OUT.
REQ-007 asic_ui  out  8  drives ASIC ui_in: [7] ack, [6] eof, [5:0] always 0.
REQ-008 asic_uio_in  out  8  drives ASIC uio_in: response data byte.
REQ-009 prog_we, prog_addr[12:0], prog_wdata[7:0]  in  host program-memory write port.
REQ-010 in_valid, in_data[7:0]  in; in_ready  out  host-to-ASIC byte stream, valid/ready.
REQ-011 in_eof  in  1  level; host has no further input bytes.
REQ-012 out_valid, out_data[7:0]  out; out_ready  in  ASIC-to-host byte stream, valid/ready.
REQ-013 halted  out  1  sticky; ASIC issued HALT.
REQ-014 busy  out  1  FSM not in IDLE.

Function
REQ-015 FSM states IDLE, LOOKUP, ACK, DROP; one request served per four-phase handshake.
REQ-016 IDLE: on req=1 sampled at edge N, latch op, 13-bit address and data byte; go to LOOKUP.
REQ-017 LOOKUP FETCH: read program memory; ack=1 at edge N+2 with data; address >= PROG_DEPTH returns 0x00.
REQ-018 LOOKUP IN, input FIFO non-empty: pop one byte, ack=1 at edge N+1, eof=0.
REQ-019 LOOKUP IN, FIFO empty and in_eof=1: ack=1 at edge N+1, data 0x00, eof=1.
REQ-020 LOOKUP IN, FIFO empty and in_eof=0: stay in LOOKUP, ack=0, until either condition above holds.
REQ-021 LOOKUP OUT: push latched byte when output FIFO not full, ack at next edge; when full, stall in LOOKUP with ack=0.
REQ-022 LOOKUP HALT: set halted, ack at edge N+1, data 0x00.
REQ-023 ACK: hold ack=1, asic_uio_in and eof stable; on req=0 clear ack at next edge, go to DROP.
REQ-024 DROP: one-cycle gap, return to IDLE; a request is never accepted in the same cycle ack falls.
REQ-025 Input FIFO: in_ready = not full; push on in_valid & in_ready; simultaneous push and pop allowed when non-empty.
REQ-026 Output FIFO: out_valid = not empty; pop on out_valid & out_ready; simultaneous push and pop allowed when not full.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; an occupancy counter of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
REQ-028 prog_we is honoured in every state; a read and write to the same address in the same cycle returns the old data.
REQ-029 prog_addr >= PROG_DEPTH writes are dropped.
REQ-030 Once halted is set, further requests are still served; halted clears only on rst.

Reset
REQ-031 On rst: FSM=IDLE; asic_ui=0x00; asic_uio_in=0x00; both FIFOs empty (in_ready=1, out_valid=0, out_data=0x00); halted=0; busy=0.
REQ-032 Program memory contents are not reset.
REQ-033 rst asserted mid-handshake aborts the handshake; a popped input byte is lost, a pushed output byte is discarded.

Structure
REQ-034 Shared package bf_pkg holds the op encoding (OP_FETCH, OP_IN, OP_OUT, OP_HALT), the FSM state enum, and bit indices REQ_BIT, ACK_BIT and EOF_BIT.
REQ-035 One sub-module bf_byte_fifo (parameter DEPTH) is instantiated twice; program memory is an inferred synchronous-read array in the top.

Verification
REQ-036 Load 0x2B at addr 5; FETCH addr 5 at edge N -> ack=1 at edge N+2 with asic_uio_in=0x2B; ack falls the edge after req drops.
REQ-037 FETCH addr 300 with PROG_DEPTH=256 -> data 0x00, ack at edge N+2.
REQ-038 IN with empty FIFO and in_eof=0 -> ack=0 for 10 cycles; then push 0x41 -> ack next edge, data 0x41, eof=0; in_eof=1 with empty FIFO -> eof=1, data 0x00.
REQ-039 Nine OUT requests (0x00..0x08) with out_ready=0 and FIFO_DEPTH=8 -> 8 acked, 9th stalls; one pop -> 9th acked; host then reads 0x01..0x08 in order.
REQ-040 HALT -> halted=1 at edge N+1; rst asserted during ACK of an IN -> next edge asic_ui=0x00, FIFOs empty, halted=0.
